hazard_fwd_ctrl: RTL
====================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Producer/control side of the D/E/M bypass network. Tracks the destination register, result class
//  and Tnew of the instructions in E, M and W, and compares them with D-stage operands and their Tuse.
//  Drives the Forward_sel codes for the D, E and M forwarding muxes, and the pipeline stall.
//  Also owns the HI/LO multiply/divide busy counter.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a mult/multu leaves E
//  DIV_CYCLES   10  busy cycles after a div/divu leaves E
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  synchronous, active-high
//  rs_d,rt_d    in   5  D-stage source register numbers
//  tuse_rs_d    in   2  cycles until rs is needed (0 branch/jr, 1 ALU, 2 store data, 3 unused)
//  tuse_rt_d    in   2  same, for rt
//  a3_d         in   5  D-stage destination register (0 = no write)
//  res_d        in   2  result class: 0 NONE, 1 ALU, 2 DM (load), 3 PC8 (jal/jalr)
//  md_start_d   in   1  D instruction starts mult/div
//  md_div_d     in   1  qualifies md_start_d: 1 = div, 0 = mult
//  md_use_d     in   1  D instruction reads/writes HI/LO or starts mult/div
//  fwd_rs_d     out  3  D-mux select: 0 PRE, 1 ALUOUT_M, 2 mux_Wdata, 3 PC8_M, 4 PC8_W
//  fwd_rt_d     out  3  same encoding
//  fwd_rs_e     out  3  E-mux select, same encoding
//  fwd_rt_e     out  3  same encoding
//  fwd_rt_m     out  2  M-mux select: 0 PRE, 1 mux_Wdata, 2 PC8_W
//  stall        out  1  freeze PC and IF/ID; clear ID/EX (insert bubble)
//  md_busy      out  1  mult/div counter non-zero (debug/observe)
// BEHAVIOUR
//  - Entry per stage E/M/W: {rs, rt, a3, res, tnew}. a3 = 0 or res = NONE means the entry never matches.
//  - Tnew at E entry: ALU 1, PC8 1, DM 2, NONE 0.
//    Tnew means cycles until the value sits in a forwardable register (M or W).
//  - Each clock: W <= M; M <= E with tnew-1, saturating at 0; E <= D fields, or all-zero bubble if stall.
//  - Stall when either condition holds:
//    - reg r in {rs_d (tuse_rs_d != 3), rt_d (tuse_rt_d != 3)}, r != 0, r == a3 of E or M,
//      and that entry's tnew > tuse.
//    - md_use_d && (md_busy || E entry started mult/div).
//  - D/E forward for operand r (r != 0), M checked before W:
//    - M match with tnew 0: sel 1 if ALU, 3 if PC8.
//    - Else W match: sel 2 if ALU/DM, 4 if PC8.
//    - Else 0. DM in M is never forwarded (tnew 1; stall covers it).
//  - M forward for rt_m: W match with rt_m != 0 -> 2 if PC8, else 1; otherwise 0.
//  - All fwd_* and stall are combinational from stage entries plus D inputs. No added latency.
//  - Forward selects are computed even while stall = 1. They are valid for the stalled D instruction.
//  - md counter: loaded with MULT_CYCLES or DIV_CYCLES on the cycle a md-start entry leaves E,
//    then decrements to 0. md_busy = (count != 0).
//    A new start while busy cannot occur: it stalls in D.
//  - Reset: all entries zero, counter 0.
//    All outputs therefore read 0 in the cycle after reset is sampled.
//    Reset overrides stall, shift and counter load in the same cycle.
//  - Register 0 never causes a forward or a stall, even if an entry claims a3 = 0.
// STRUCTURE
//  - Shared package/header: result-class codes (RES_NONE/ALU/DM/PC8),
//    forward-select codes (FWD_PRE, FWD_ALUOUT_M, FWD_WDATA, FWD_PC8_M, FWD_PC8_W, FWD_M_*),
//    and the Tuse "unused" code 3.
//  - One sub-module, hazard_stage_entry: a registered entry with optional bubble-clear and
//    saturating tnew decrement. Instantiated three times for E, M, W.
//  - Top level holds the compare logic, stall logic and md counter.
// TESTING
//  1. ALU-ALU: addu $3 then addu $4,$3,$3 (tuse 1).
//     -> no stall; next cycle fwd_rs_e = fwd_rt_e = 1; one cycle later, with E two apart, sel = 2.
//  2. Load-use: lw $5 then addu $6,$5,$0 (tuse 1).
//     -> stall = 1 for exactly one cycle, E bubble, then fwd_rs_e = 2 from W.
//  3. Branch after ALU: addu $7 then beq $7 (tuse 0).
//     -> stall 1 cycle, then fwd_rs_d = 1 with producer in M; load-then-beq -> 2 stall cycles.
//  4. jal then jr $31 in D two cycles later -> fwd_rs_d = 3 (PC8_M); three later -> 4 (PC8_W).
//  5. Store data: lw $8 directly followed by sw $8 (rt tuse 2).
//     -> no stall; when sw reaches M, fwd_rt_m = 1. Write to $0 followed by a reader -> all sel 0, no stall.
//  6. div then mfhi -> stall held DIV_CYCLES+1 cycles.
//     - reset asserted mid-count -> md_busy = 0 and stall = 0 the next cycle.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the D/E/M hazard and forwarding controller.
//  - Result-class codes describing what a pipeline entry will write back.
//  - Forward-select codes driven onto the D/E bypass muxes and the M-stage mux.
//  - Tuse code for "operand not read".
//  - The stage entry record carried through E, M and W.
package hazard_fwd_ctrl_pkg;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_ALU  = 2'd1;
    localparam logic [1:0] RES_DM   = 2'd2;
    localparam logic [1:0] RES_PC8  = 2'd3;

    localparam logic [2:0] FWD_PRE      = 3'd0;
    localparam logic [2:0] FWD_ALUOUT_M = 3'd1;
    localparam logic [2:0] FWD_WDATA    = 3'd2;
    localparam logic [2:0] FWD_PC8_M    = 3'd3;
    localparam logic [2:0] FWD_PC8_W    = 3'd4;

    localparam logic [1:0] FWD_M_PRE    = 2'd0;
    localparam logic [1:0] FWD_M_WDATA  = 2'd1;
    localparam logic [1:0] FWD_M_PC8_W  = 2'd2;

    localparam logic [1:0] TUSE_UNUSED  = 2'd3;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic [1:0] res;
        logic [1:0] tnew;
        logic       md_start;
        logic       md_div;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Cycles until a freshly issued result reaches a forwardable register.
    function automatic logic [1:0] tnew_at_e(input logic [1:0] res);
        logic [1:0] t;
        case (res)
            RES_ALU: t = 2'd1;
            RES_PC8: t = 2'd1;
            RES_DM:  t = 2'd2;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/hazard_stage_entry.sv
// One pipeline-stage hazard entry (E, M or W).
// Ports:
//  clk    in  rising-edge clock
//  reset  in  synchronous active-high reset, empties the entry
//  clear  in  load an all-zero bubble instead of d
//  d      in  incoming entry (packed entry_t)
//  q      out current entry (packed entry_t)
// DEC_TNEW selects a saturating decrement of tnew as the entry is loaded.
module hazard_stage_entry
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter bit DEC_TNEW = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [ENTRY_W-1:0] d,
    output logic [ENTRY_W-1:0] q
);

    entry_t d_e;
    entry_t nxt;
    entry_t q_r;

    assign d_e = d;

    always_comb begin
        nxt = d_e;
        if (DEC_TNEW && (d_e.tnew != 2'd0)) begin
            nxt.tnew = d_e.tnew - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q_r <= '0;
        end else begin
            q_r <= nxt;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and bypass-select generation for a 5-stage pipeline.
// Tracks E/M/W producer entries, compares them with D-stage operands and
// their Tuse, drives the D/E/M forward selects and the stall, and keeps
// the HI/LO multiply/divide busy counter.
// Ports:
//  clk, reset            clock, synchronous active-high reset
//  rs_d, rt_d            D-stage source registers
//  tuse_rs_d, tuse_rt_d  cycles until each source is needed (3 = unused)
//  a3_d, res_d           D-stage destination and result class
//  md_start_d, md_div_d  D instruction starts mult (0) / div (1)
//  md_use_d              D instruction touches HI/LO or starts mult/div
//  fwd_rs_d, fwd_rt_d    D-mux selects
//  fwd_rs_e, fwd_rt_e    E-mux selects
//  fwd_rt_m              M-mux select
//  stall                 freeze PC and IF/ID, bubble into E
//  md_busy               mult/div counter non-zero
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] a3_d,
    input  logic [1:0] res_d,
    input  logic       md_start_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    output logic [2:0] fwd_rs_d,
    output logic [2:0] fwd_rt_d,
    output logic [2:0] fwd_rs_e,
    output logic [2:0] fwd_rt_e,
    output logic [1:0] fwd_rt_m,
    output logic       stall,
    output logic       md_busy
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    entry_t d_ent;
    entry_t e_q;
    entry_t m_q;
    entry_t w_q;
    logic [ENTRY_W-1:0] e_raw;
    logic [ENTRY_W-1:0] m_raw;
    logic [ENTRY_W-1:0] w_raw;
    logic [CNT_W-1:0]   md_cnt;
    logic               data_stall;
    logic               md_stall;

    // An entry with a3 = 0 or no result never produces a match, so $0 is
    // never forwarded and never stalls.
    function automatic logic hit(input logic [4:0] r, input entry_t x);
        return (r != 5'd0) && (x.a3 == r) && (x.res != RES_NONE);
    endfunction

    // D/E bypass select: M wins over W; M only once its value is ready.
    function automatic logic [2:0] fwd_de(input logic [4:0] r, input entry_t m, input entry_t w);
        logic [2:0] sel;
        sel = FWD_PRE;
        if (hit(r, m) && (m.tnew == 2'd0) && (m.res == RES_ALU)) begin
            sel = FWD_ALUOUT_M;
        end else if (hit(r, m) && (m.tnew == 2'd0) && (m.res == RES_PC8)) begin
            sel = FWD_PC8_M;
        end else if (hit(r, w)) begin
            sel = (w.res == RES_PC8) ? FWD_PC8_W : FWD_WDATA;
        end
        return sel;
    endfunction

    function automatic logic stall_on(input logic [4:0] r, input logic [1:0] tuse, input entry_t x);
        return (tuse != TUSE_UNUSED) && hit(r, x) && (x.tnew > tuse);
    endfunction

    always_comb begin
        d_ent          = '0;
        d_ent.rs       = rs_d;
        d_ent.rt       = rt_d;
        d_ent.a3       = a3_d;
        d_ent.res      = res_d;
        d_ent.tnew     = tnew_at_e(res_d);
        d_ent.md_start = md_start_d;
        d_ent.md_div   = md_div_d;
    end

    // ---- D -> E boundary: bubble replaces the D instruction on stall
    hazard_stage_entry #(.DEC_TNEW(1'b0)) u_e (
        .clk   (clk),
        .reset (reset),
        .clear (stall),
        .d     (d_ent),
        .q     (e_raw)
    );

    // ---- E -> M boundary: one cycle closer to its result
    hazard_stage_entry #(.DEC_TNEW(1'b1)) u_m (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .d     (e_raw),
        .q     (m_raw)
    );

    // ---- M -> W boundary
    hazard_stage_entry #(.DEC_TNEW(1'b0)) u_w (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .d     (m_raw),
        .q     (w_raw)
    );

    assign e_q = e_raw;
    assign m_q = m_raw;
    assign w_q = w_raw;

    assign data_stall = stall_on(rs_d, tuse_rs_d, e_q) || stall_on(rs_d, tuse_rs_d, m_q) ||
                        stall_on(rt_d, tuse_rt_d, e_q) || stall_on(rt_d, tuse_rt_d, m_q);
    assign md_stall   = md_use_d && (md_busy || e_q.md_start);
    assign stall      = data_stall || md_stall;

    assign fwd_rs_d = fwd_de(rs_d, m_q, w_q);
    assign fwd_rt_d = fwd_de(rt_d, m_q, w_q);
    assign fwd_rs_e = fwd_de(e_q.rs, m_q, w_q);
    assign fwd_rt_e = fwd_de(e_q.rt, m_q, w_q);
    assign fwd_rt_m = !hit(m_q.rt, w_q)   ? FWD_M_PRE :
                      (w_q.res == RES_PC8) ? FWD_M_PC8_W : FWD_M_WDATA;

    // The counter starts as the mult/div leaves E; a second start cannot
    // arrive while busy because it is held in D by md_stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (e_q.md_start) begin
            md_cnt <= e_q.md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    assign md_busy = (md_cnt != '0);

    // Fields carried for uniformity but not consumed in every stage.
    logic unused_fields;
    assign unused_fields = ^{m_q.rs, m_q.md_start, m_q.md_div,
                             w_q.rs, w_q.rt, w_q.tnew, w_q.md_start, w_q.md_div};

endmodule
